rv_multicycle_seq: RTL and testbench

- Multi-cycle sequencer for the RISC-V core; drives the datapath through FETCH/DECODE/EXEC/MEM/WB, one instruction at a time.
- Consumes the one-hot instruction-class lines (R, I, L, S, B, J, Jr, lui, aui) that feed controlDecode. Uses them to choose the phase path, and generates the per-phase enables and memory handshakes.
- Sits between the instruction/data memory ports and the existing control decode and datapath.

---
 rtl/rv_pkg.sv | 49 ++++
 rtl/rv_mem_wait.sv | 34 +++
 rtl/rv_multicycle_seq.sv | 159 +++++++++++++++
 tb/tb_rv_multicycle_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types and constants for the multi-cycle RISC-V sequencer.
// Holds the state encoding, trap causes, class bit positions and class-resolution helpers.
package rv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd7
  } seq_state_t;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_IMEM    = 2'b10;
  localparam logic [1:0] TRAP_DMEM    = 2'b11;

  localparam int NUM_CLS = 9;
  localparam int CLS_R   = 0;
  localparam int CLS_I   = 1;
  localparam int CLS_L   = 2;
  localparam int CLS_S   = 3;
  localparam int CLS_B   = 4;
  localparam int CLS_J   = 5;
  localparam int CLS_JR  = 6;
  localparam int CLS_LUI = 7;
  localparam int CLS_AUI = 8;

  typedef logic [NUM_CLS-1:0] cls_vec_t;

  // controlDecode lets lui/aui override R, so R is dropped when either is present.
  function automatic cls_vec_t resolve_cls(input cls_vec_t raw);
    cls_vec_t v;
    v = raw;
    if (raw[CLS_R] && (raw[CLS_LUI] || raw[CLS_AUI])) v[CLS_R] = 1'b0;
    return v;
  endfunction

  // Hand-rolled one-hot test keeps the decode legality check tool-neutral.
  function automatic logic is_one_hot(input cls_vec_t v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_CLS; i++) n = n + int'(v[i]);
    return (n == 1);
  endfunction

endpackage

// File: rtl/rv_mem_wait.sv
// Memory wait-cycle counter shared by the fetch and data-access phases.
// done flags an accepted ack; timeout flags the last wait cycle passing without one.
module rv_mem_wait #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic req,
  input  logic ack,
  output logic done,
  output logic timeout
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (req && !ack && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // An ack in the final wait cycle still counts as done, so it wins over the timeout.
  assign done    = req & ack;
  assign timeout = req & ~ack & (cnt == LAST);

endmodule

// File: rtl/rv_multicycle_seq.sv
// Multi-cycle sequencer: walks one instruction through FETCH/DECODE/EXEC/MEM/WB.
// Handshake: a request is held high each cycle until its ack; the ack cycle completes the access.
module rv_multicycle_seq
  import rv_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             R,
  input  logic             I,
  input  logic             L,
  input  logic             S,
  input  logic             B,
  input  logic             J,
  input  logic             Jr,
  input  logic             lui,
  input  logic             aui,
  input  logic             br_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_write,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             pc_write,
  output logic             pc_sel,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state
);

  seq_state_t cur, nxt;
  cls_vec_t   cls_raw, cls_res, cls_q;
  logic       br_q, br_eff;
  logic [1:0] cause_q, cause_nxt;
  logic       mw_start, mw_req, mw_ack, mw_done, mw_timeout;
  logic       retire;

  assign cls_raw = {aui, lui, Jr, J, B, S, L, I, R};
  assign cls_res = resolve_cls(cls_raw);

  assign mw_req   = (cur == ST_FETCH) || (cur == ST_MEM);
  assign mw_ack   = (cur == ST_FETCH) ? imem_ack : dmem_ack;
  assign mw_start = ((nxt == ST_FETCH) || (nxt == ST_MEM)) && (nxt != cur);

  rv_mem_wait #(.TIMEOUT(TIMEOUT)) u_mem_wait (
    .clk     (clk),
    .rst     (rst),
    .start   (mw_start),
    .req     (mw_req),
    .ack     (mw_ack),
    .done    (mw_done),
    .timeout (mw_timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= ST_IDLE;
    else      cur <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cls_q   <= '0;
      br_q    <= 1'b0;
      cause_q <= TRAP_NONE;
      instret <= '0;
    end else begin
      if (cur == ST_DECODE) cls_q <= cls_res;
      if (cur == ST_EXEC)   br_q  <= br_taken;
      if ((nxt == ST_TRAP) && (cur != ST_TRAP)) cause_q <= cause_nxt;
      if (retire) instret <= instret + 1'b1;
    end
  end

  // Branches retire in EXEC, before br_q has captured the comparator result.
  assign br_eff = (cur == ST_EXEC) ? br_taken : br_q;

  always_comb begin
    nxt        = cur;
    cause_nxt  = TRAP_NONE;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    alu_en     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    unique case (cur)
      ST_IDLE: if (run) nxt = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (mw_done) begin
          ir_write = 1'b1;
          nxt      = ST_DECODE;
        end else if (mw_timeout) begin
          nxt       = ST_TRAP;
          cause_nxt = TRAP_IMEM;
        end
      end
      ST_DECODE: begin
        if (is_one_hot(cls_res)) begin
          nxt = ST_EXEC;
        end else begin
          nxt       = ST_TRAP;
          cause_nxt = TRAP_ILLEGAL;
        end
      end
      ST_EXEC: begin
        alu_en = 1'b1;
        if (cls_q[CLS_B]) begin
          retire = 1'b1;
          nxt    = ST_IDLE;
        end else if (cls_q[CLS_L] || cls_q[CLS_S]) begin
          nxt = ST_MEM;
        end else begin
          nxt = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls_q[CLS_S];
        if (mw_done) begin
          if (cls_q[CLS_S]) begin
            retire = 1'b1;
            nxt    = ST_IDLE;
          end else begin
            nxt = ST_WB;
          end
        end else if (mw_timeout) begin
          nxt       = ST_TRAP;
          cause_nxt = TRAP_DMEM;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = cls_q[CLS_L];
        retire     = 1'b1;
        nxt        = ST_IDLE;
      end
      ST_TRAP: nxt = ST_TRAP;
      default: nxt = ST_IDLE;
    endcase
  end

  assign pc_write   = retire;
  assign pc_sel     = retire & (cls_q[CLS_J] | cls_q[CLS_JR] | (cls_q[CLS_B] & br_eff));
  assign trap       = (cur == ST_TRAP);
  assign trap_cause = cause_q;
  assign state      = cur;

endmodule

// File: tb/tb_rv_multicycle_seq.sv
// Directed bench for rv_multicycle_seq: walks each instruction class through the sequencer
// and compares phase strobes, latencies, retire counts and trap behaviour against hand values.
module tb_rv_multicycle_seq;
  import rv_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;

  localparam logic [8:0] C_R   = 9'h001;
  localparam logic [8:0] C_I   = 9'h002;
  localparam logic [8:0] C_L   = 9'h004;
  localparam logic [8:0] C_S   = 9'h008;
  localparam logic [8:0] C_B   = 9'h010;
  localparam logic [8:0] C_J   = 9'h020;
  localparam logic [8:0] C_LUI = 9'h080;

  logic clk, rst, run;
  logic R, I, L, S, B, J, Jr, lui, aui, br_taken;
  logic imem_req, imem_ack, ir_write, alu_en, dmem_req, dmem_we, dmem_ack;
  logic reg_write, mem_to_reg, pc_write, pc_sel, trap;
  logic [CNT_W-1:0] instret;
  logic [1:0] trap_cause;
  logic [2:0] state;

  int n_checks, n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] exp_instret;

  int obs_cycles, ir_cnt, ir_idx, rw_cnt, rw_idx, pcw_cnt, pcw_idx, alu_cnt, dreq_cnt;
  logic pc_sel_ret, m2r_rw, dwe_seen;

  rv_multicycle_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run),
    .R(R), .I(I), .L(L), .S(S), .B(B), .J(J), .Jr(Jr), .lui(lui), .aui(aui),
    .br_taken(br_taken),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_write(ir_write), .alu_en(alu_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_sel(pc_sel),
    .instret(instret), .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    {aui, lui, Jr, J, B, S, L, I, R} = '0;
    br_taken = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    run      = 1'b0;
  endtask

  task automatic push_retire();
    exp_instret = exp_instret + 1;
    exp_q.push_back(exp_instret);
  endtask

  task automatic check_instret(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_instret;
    check(tag, instret, e);
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    exp_instret = 0;
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // driver: starts one instruction from IDLE and follows it until IDLE or TRAP
  task automatic exec_instr(input logic [8:0] cls, input logic br, input int imem_wait,
                            input int dmem_wait, input int abort_at);
    int f_n, m_n, guard;
    obs_cycles = 0; ir_cnt = 0; ir_idx = 0; rw_cnt = 0; rw_idx = 0;
    pcw_cnt = 0; pcw_idx = 0; alu_cnt = 0; dreq_cnt = 0;
    pc_sel_ret = 1'b0; m2r_rw = 1'b0; dwe_seen = 1'b0;
    f_n = 0; m_n = 0; guard = 0;
    run = 1'b1;
    @(posedge clk); #1;
    while ((state != ST_IDLE) && (state != ST_TRAP) && (guard < 100)) begin
      guard++;
      clear_inputs();
      case (state)
        ST_FETCH:  begin imem_ack = (f_n == imem_wait); f_n++; end
        ST_DECODE: {aui, lui, Jr, J, B, S, L, I, R} = cls;
        ST_EXEC:   br_taken = br;
        ST_MEM:    begin dmem_ack = (m_n == dmem_wait); m_n++; end
        default: ;
      endcase
      #1;
      obs_cycles++;
      if (ir_write) begin ir_cnt++; ir_idx = obs_cycles; end
      if (alu_en) alu_cnt++;
      if (dmem_req) begin dreq_cnt++; dwe_seen = dwe_seen | dmem_we; end
      if (reg_write) begin rw_cnt++; rw_idx = obs_cycles; m2r_rw = mem_to_reg; end
      if (pc_write) begin pcw_cnt++; pcw_idx = obs_cycles; pc_sel_ret = pc_sel; end
      if ((abort_at >= 0) && (state == ST_MEM) && (m_n == abort_at + 1)) begin
        #1 rst = 1'b0;
        #1 clear_inputs();
        return;
      end
      @(posedge clk); #1;
    end
    if (guard >= 100) check("guard_budget", 32'(guard), 32'd0);
    clear_inputs();
  endtask

  task automatic hold_in_trap(input int n);
    int pcw_seen;
    pcw_seen = 0;
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (n) begin
      @(posedge clk); #2;
      if (pc_write || imem_req || dmem_req) pcw_seen++;
    end
    check("trap_hold_state", 32'(state), 32'(ST_TRAP));
    check("trap_hold_strobes", 32'(pcw_seen), 32'd0);
    clear_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; exp_instret = 0;
    clear_inputs();
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_strobes", 32'({imem_req, ir_write, alu_en, dmem_req, dmem_we,
                              reg_write, mem_to_reg, pc_write, pc_sel}), 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_trap", 32'({trap, trap_cause}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    exec_instr(C_R, 1'b0, 0, 0, -1);
    push_retire();
    check("r_cycles", 32'(obs_cycles), 32'd4);
    check("r_ir_idx", 32'(ir_idx), 32'd1);
    check("r_rw_idx", 32'(rw_idx), 32'd4);
    check("r_pcw_idx", 32'(pcw_idx), 32'd4);
    check("r_pc_sel", 32'(pc_sel_ret), 32'd0);
    check("r_alu", 32'(alu_cnt), 32'd1);
    check_instret("r_instret");

    exec_instr(C_L, 1'b0, 0, 3, -1);
    push_retire();
    check("l_cycles", 32'(obs_cycles), 32'd8);
    check("l_dreq", 32'(dreq_cnt), 32'd4);
    check("l_we", 32'(dwe_seen), 32'd0);
    check("l_m2r", 32'(m2r_rw), 32'd1);
    check("l_rw", 32'(rw_cnt), 32'd1);
    check_instret("l_instret");

    exec_instr(C_B, 1'b1, 0, 0, -1);
    push_retire();
    check("bt_cycles", 32'(obs_cycles), 32'd3);
    check("bt_pc_sel", 32'(pc_sel_ret), 32'd1);
    check("bt_rw", 32'(rw_cnt), 32'd0);
    check("bt_pcw_idx", 32'(pcw_idx), 32'd3);
    exec_instr(C_B, 1'b0, 0, 0, -1);
    push_retire();
    check("bn_pc_sel", 32'(pc_sel_ret), 32'd0);
    check("bn_pcw", 32'(pcw_cnt), 32'd1);
    check("bn_rw", 32'(rw_cnt), 32'd0);
    void'(exp_q.pop_front());
    check_instret("b_instret");

    exec_instr(C_J, 1'b0, 2, 0, -1);
    push_retire();
    check("j_cycles", 32'(obs_cycles), 32'd6);
    check("j_ir_idx", 32'(ir_idx), 32'd3);
    check("j_pc_sel", 32'(pc_sel_ret), 32'd1);
    check_instret("j_instret");

    exec_instr(C_S, 1'b0, 0, 0, -1);
    push_retire();
    check("s_cycles", 32'(obs_cycles), 32'd4);
    check("s_we", 32'(dwe_seen), 32'd1);
    check("s_rw", 32'(rw_cnt), 32'd0);
    check("s_pcw_idx", 32'(pcw_idx), 32'd4);
    check_instret("s_instret");

    exec_instr(C_R | C_LUI, 1'b0, 0, 0, -1);
    push_retire();
    check("rlui_cycles", 32'(obs_cycles), 32'd4);
    check("rlui_trap", 32'(trap), 32'd0);
    check("rlui_rw", 32'(rw_cnt), 32'd1);
    check_instret("rlui_instret");

    // ack in the last permitted wait cycle must still be accepted
    exec_instr(C_R, 1'b0, TIMEOUT - 1, 0, -1);
    push_retire();
    check("late_ack_cycles", 32'(obs_cycles), 32'd7);
    check("late_ack_trap", 32'(trap), 32'd0);
    check_instret("late_ack_instret");

    exec_instr(C_L, 1'b0, 0, 100, 1);
    check("abort_state", 32'(state), 32'(ST_IDLE));
    check("abort_strobes", 32'({imem_req, dmem_req, reg_write, pc_write, alu_en}), 32'd0);
    check("abort_instret", instret, 32'd0);
    check("abort_pcw", 32'(pcw_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_instret = 0;
    exp_q.delete();
    @(posedge clk); #1;
    exec_instr(C_R, 1'b0, 0, 0, -1);
    push_retire();
    check("post_abort_ir_idx", 32'(ir_idx), 32'd1);
    check_instret("post_abort_instret");

    exec_instr(C_I | C_L, 1'b0, 0, 0, -1);
    check("ill_state", 32'(state), 32'(ST_TRAP));
    check("ill_trap", 32'({trap, trap_cause}), {29'd0, 1'b1, TRAP_ILLEGAL});
    check("ill_alu", 32'(alu_cnt), 32'd0);
    check("ill_pcw", 32'(pcw_cnt), 32'd0);
    hold_in_trap(5);

    reset_dut();
    exec_instr(C_S, 1'b0, 0, 100, -1);
    check("dto_dreq", 32'(dreq_cnt), 32'(TIMEOUT));
    check("dto_cycles", 32'(obs_cycles), 32'(3 + TIMEOUT));
    check("dto_trap", 32'({trap, trap_cause}), {29'd0, 1'b1, TRAP_DMEM});
    check("dto_pcw", 32'(pcw_cnt), 32'd0);
    hold_in_trap(4);
    check("dto_instret", instret, 32'd0);

    reset_dut();
    exec_instr(C_R, 1'b0, 100, 0, -1);
    check("ito_trap", 32'({trap, trap_cause}), {29'd0, 1'b1, TRAP_IMEM});
    check("ito_ir", 32'(ir_cnt), 32'd0);
    check("ito_cycles", 32'(obs_cycles), 32'(TIMEOUT));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
